// File: rtl/pe_cube_sched.sv
// Sequencer for the pe_cube systolic datapath: runs convolution blocks back-to-back,
// generating clear, per-lane pattern codes, pass-left bits and fetch addresses.
module pe_cube_sched #(
  parameter int ARRAY_NUM = 3,
  parameter int ROWS      = 3,
  parameter int PIPE_LAT  = 4,
  parameter int ADDR_W    = 8,
  parameter int BLK_W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [BLK_W-1:0]         blocks,
  input  logic [4:0]               output_left_shift,
  input  logic                     stall,
  output logic                     busy,
  output logic                     clear_acc,
  output logic                     fetch_en,
  output logic [ADDR_W-1:0]        data_addr,
  output logic [ADDR_W-1:0]        weight_addr,
  output logic [3*ARRAY_NUM-1:0]   cfs_input_pattern,
  output logic [ARRAY_NUM-2:0]     cfs_pass_data_left,
  output logic [4:0]               cfs_output_left_shift,
  output logic                     result_valid,
  output logic                     done
);

  localparam int LEN     = 2 + 3 * ROWS;
  localparam int STEPS   = LEN + ARRAY_NUM - 1;
  localparam int PW      = 3 * ARRAY_NUM;
  localparam int DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [2:0]    CODE_P1 = 3'd0;
  localparam logic [2:0]    CODE_P2 = 3'd1;
  localparam logic [2:0]    CODE_NC = 3'd5;
  localparam logic [PW-1:0] ALL_NC  = {ARRAY_NUM{CODE_NC}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  // Lane a sees the step stream delayed by a cycles (systolic skew).
  function automatic logic [PW-1:0] step_pattern(input logic [ADDR_W-1:0] step);
    logic [PW-1:0] pat;
    int            t;
    pat = ALL_NC;
    for (int a = 0; a < ARRAY_NUM; a++) begin
      t = int'(step) - a;
      if (t == 0)
        pat[3*a +: 3] = CODE_P1;
      else if (t == 1)
        pat[3*a +: 3] = CODE_P2;
      else if (t >= 2 && t < LEN)
        pat[3*a +: 3] = 3'(2 + ((t - 2) % 3));
    end
    return pat;
  endfunction

  function automatic logic [ARRAY_NUM-2:0] pass_bits(input logic [PW-1:0] pat);
    logic [ARRAY_NUM-2:0] p;
    logic [2:0]           code;
    p = '0;
    for (int j = 0; j < ARRAY_NUM - 1; j++) begin
      code = pat[3*j +: 3];
      p[j] = (code >= 3'd2) && (code <= 3'd4);
    end
    return p;
  endfunction

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    s_q, s_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic [BLK_W-1:0]     blocks_q, blocks_d;

  logic                 busy_d, clear_d, fetch_d, valid_d, done_d;
  logic [ADDR_W-1:0]    addr_d;
  logic [PW-1:0]        pat_d, step_pat;
  logic [ARRAY_NUM-2:0] pass_d;
  logic [4:0]           shift_d;

  assign step_pat = step_pattern(s_q);

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; a missed branch in always_comb would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    drain_d  = drain_q;
    blocks_d = blocks_q;
    shift_d  = cfs_output_left_shift;
    clear_d  = 1'b0;
    fetch_d  = 1'b0;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    addr_d   = data_addr;
    pat_d    = cfs_input_pattern;
    pass_d   = cfs_pass_data_left;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          blocks_d = (blocks == '0) ? BLK_W'(1) : blocks;
          shift_d  = output_left_shift;
          clear_d  = 1'b1;
          state_d  = S_CLEAR;
        end
      end
      S_CLEAR: begin
        // The first RUN cycle always presents step 0; s_q then names the next step.
        fetch_d = 1'b1;
        addr_d  = '0;
        pat_d   = step_pattern('0);
        pass_d  = pass_bits(step_pattern('0));
        s_d     = ADDR_W'(1);
        state_d = S_RUN;
      end
      S_RUN: begin
        if (s_q == ADDR_W'(STEPS)) begin
          pat_d   = ALL_NC;
          pass_d  = '0;
          drain_d = '0;
          state_d = S_DRAIN;
        end else if (!stall) begin
          fetch_d = 1'b1;
          addr_d  = s_q;
          pat_d   = step_pat;
          pass_d  = pass_bits(step_pat);
          s_d     = s_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        drain_d = drain_q + DRAIN_W'(1);
        if (drain_q == DRAIN_W'(PIPE_LAT - 1)) begin
          valid_d  = 1'b1;
          done_d   = (blocks_q == BLK_W'(1));
          blocks_d = blocks_q - BLK_W'(1);
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (blocks_q != '0) begin
          clear_d = 1'b1;
          state_d = S_CLEAR;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q               <= S_IDLE;
      s_q                   <= '0;
      drain_q               <= '0;
      blocks_q              <= '0;
      busy                  <= 1'b0;
      clear_acc             <= 1'b0;
      fetch_en              <= 1'b0;
      data_addr             <= '0;
      weight_addr           <= '0;
      cfs_input_pattern     <= ALL_NC;
      cfs_pass_data_left    <= '0;
      cfs_output_left_shift <= '0;
      result_valid          <= 1'b0;
      done                  <= 1'b0;
    end else begin
      state_q               <= state_d;
      s_q                   <= s_d;
      drain_q               <= drain_d;
      blocks_q              <= blocks_d;
      busy                  <= busy_d;
      clear_acc             <= clear_d;
      fetch_en              <= fetch_d;
      data_addr             <= addr_d;
      weight_addr           <= addr_d;
      cfs_input_pattern     <= pat_d;
      cfs_pass_data_left    <= pass_d;
      cfs_output_left_shift <= shift_d;
      result_valid          <= valid_d;
      done                  <= done_d;
    end
  end

endmodule
